// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 mux: walks the selects through channels 0..3, samples y after a
// programmable settle time on each, and publishes all four bits at once with a done pulse.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4,
  parameter bit          CONTINUOUS    = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       y_i,
  output logic       s0_o,
  output logic       s1_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] sample_vec_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       shadow_q;
  logic [3:0]       sample_vec_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       captured;

  // Shadow with the current channel's bit replaced by y, so the last channel's sample can be
  // published on the same edge it is taken.
  always_comb begin
    captured = shadow_q;
    for (int i = 0; i < 4; i++) begin
      if (sel_q == 2'(i)) begin
        captured[i] = y_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      sel_q        <= 2'd0;
      cnt_q        <= '0;
      shadow_q     <= 4'd0;
      sample_vec_q <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && (state_q != StIdle)) begin
        state_q  <= StIdle;
        sel_q    <= 2'd0;
        cnt_q    <= '0;
        shadow_q <= 4'd0;
        busy_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i && !abort_i) begin
              state_q <= StSettle;
              sel_q   <= 2'd0;
              cnt_q   <= '0;
              busy_q  <= 1'b1;
            end
          end
          StSettle: begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StSample;
            end
          end
          StSample: begin
            shadow_q <= captured;
            if (sel_q == 2'd3) begin
              // sel stays at 3 through DONE; the only wrap back to 0 is on leaving DONE.
              state_q      <= StDone;
              sample_vec_q <= captured;
              done_q       <= 1'b1;
            end else begin
              state_q <= StSettle;
              sel_q   <= sel_q + 2'd1;
              cnt_q   <= '0;
            end
          end
          StDone: begin
            sel_q <= 2'd0;
            cnt_q <= '0;
            if (CONTINUOUS) begin
              state_q <= StSettle;
              busy_q  <= 1'b1;
            end else begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign s0_o         = sel_q[0];
  assign s1_o         = sel_q[1];
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign sample_vec_o = sample_vec_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: single-scan and continuous instances, each driving a
// behavioural 4:1 mux, with expected sample vectors queued at start and popped on done.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, start_a, abort_a, y_a, s0_a, s1_a, busy_a, done_a;
  logic [3:0] vec_a, mux_a;
  logic       rst_b, start_b, abort_b, y_b, s0_b, s1_b, busy_b, done_b;
  logic [3:0] vec_b, mux_b;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  // Mux inputs packed as {d,c,b,a}.
  assign y_a = mux_a[{s1_a, s0_a}];
  assign y_b = mux_b[{s1_b, s0_b}];

  mux_scan_ctrl #(
    .SETTLE_CYCLES(2),
    .CNT_W        (4),
    .CONTINUOUS   (1'b0)
  ) u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst_a),
    .start_i     (start_a),
    .abort_i     (abort_a),
    .y_i         (y_a),
    .s0_o        (s0_a),
    .s1_o        (s1_a),
    .busy_o      (busy_a),
    .done_o      (done_a),
    .sample_vec_o(vec_a)
  );

  mux_scan_ctrl #(
    .SETTLE_CYCLES(2),
    .CNT_W        (4),
    .CONTINUOUS   (1'b1)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst_b),
    .start_i     (start_b),
    .abort_i     (abort_b),
    .y_i         (y_b),
    .s0_o        (s0_b),
    .s1_o        (s1_b),
    .busy_o      (busy_b),
    .done_o      (done_b),
    .sample_vec_o(vec_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [3:0] obs);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<no queued scan>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  // One full single-shot scan on instance A, checked cycle by cycle (cycle 0 = accepting edge).
  task automatic scan_a(input logic [3:0] pat, input bit restarts);
    mux_a = pat;
    exp_q.push_back(pat);
    start_a = 1'b1;
    tick();
    for (int k = 1; k <= 14; k++) begin
      start_a = restarts && (k == 5 || k == 9);
      if (k <= 12) chk("a_sel", {2'b00, s1_a, s0_a}, 4'((k - 1) / 3));
      else if (k == 13) chk("a_sel_done", {2'b00, s1_a, s0_a}, 4'd3);
      else chk("a_sel_idle", {2'b00, s1_a, s0_a}, 4'd0);
      chk("a_busy", 4'(busy_a), 4'(k <= 13));
      chk("a_done", 4'(done_a), 4'(k == 13));
      if (done_a) pop_chk("a_vec", vec_a);
      tick();
    end
    start_a = 1'b0;
    chk("a_busy_after", 4'(busy_a), 4'd0);
    chk("a_vec_hold", vec_a, pat);
  endtask

  initial begin
    {rst_a, start_a, abort_a, rst_b, start_b, abort_b} = '0;
    mux_a = 4'b0000;
    mux_b = 4'b0000;
    rst_a = 1'b1;
    rst_b = 1'b1;
    tick();
    tick();
    chk("rst_sel", {2'b00, s1_a, s0_a}, 4'd0);
    chk("rst_busy", 4'(busy_a), 4'd0);
    chk("rst_done", 4'(done_a), 4'd0);
    chk("rst_vec", vec_a, 4'd0);
    chk("rst_b_busy", 4'(busy_b), 4'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Basic scan: a=1 b=0 c=1 d=0.
    scan_a(4'b0101, 1'b0);
    // Start re-asserted mid-scan must be ignored.
    scan_a(4'b0101, 1'b1);

    // Abort in cycle 7 with all inputs high.
    mux_a = 4'b1111;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 6; k++) tick();
    chk("abort_pre_sel", {2'b00, s1_a, s0_a}, 4'd2);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    chk("abort_sel", {2'b00, s1_a, s0_a}, 4'd0);
    chk("abort_busy", 4'(busy_a), 4'd0);
    chk("abort_vec", vec_a, 4'b0101);
    for (int k = 0; k < 8; k++) begin
      chk("abort_no_done", 4'(done_a), 4'd0);
      tick();
    end
    chk("abort_vec_hold", vec_a, 4'b0101);

    // Reset in cycle 6, then a fresh scan.
    mux_a = 4'b0011;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 5; k++) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    chk("mrst_vec", vec_a, 4'd0);
    chk("mrst_sel", {2'b00, s1_a, s0_a}, 4'd0);
    chk("mrst_busy", 4'(busy_a), 4'd0);
    chk("mrst_done", 4'(done_a), 4'd0);
    scan_a(4'b1001, 1'b0);

    // start together with abort in IDLE.
    start_a = 1'b1;
    abort_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("sa_busy", 4'(busy_a), 4'd0);
      chk("sa_sel", {2'b00, s1_a, s0_a}, 4'd0);
    end
    start_a = 1'b0;
    abort_a = 1'b0;

    // Continuous mode: a=0 b=1 c=1 d=0, d rises during channel 0 of the first scan.
    mux_b = 4'b0110;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b1110);
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      if (k == 2) mux_b[3] = 1'b1;
      if (k <= 12) chk("b_sel", {2'b00, s1_b, s0_b}, 4'((k - 1) / 3));
      else if (k == 13 || k == 26) chk("b_sel_done", {2'b00, s1_b, s0_b}, 4'd3);
      else chk("b_sel2", {2'b00, s1_b, s0_b}, 4'((k - 14) / 3));
      chk("b_busy", 4'(busy_b), 4'd1);
      chk("b_done", 4'(done_b), 4'(k == 13 || k == 26));
      if (done_b) pop_chk("b_vec", vec_b);
      tick();
    end
    chk("b_still_busy", 4'(busy_b), 4'd1);
    abort_b = 1'b1;
    tick();
    abort_b = 1'b0;
    chk("b_abort_busy", 4'(busy_b), 4'd0);
    chk("b_abort_sel", {2'b00, s1_b, s0_b}, 4'd0);
    chk("b_abort_vec", vec_b, 4'b1110);

    chk("sb_empty", 4'(exp_q.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
